// File: rtl/wait_gen_if.sv
// Bus-side signals of the nWAIT stretch generator, grouped for the 6309E clock generator.
// nWAIT low is a stretch request; the CPU holds E (nE low) for as long as nWAIT stays low.
interface wait_gen_if;
    logic nQ;
    logic nE;
    logic nCS_ROM;
    logic nCS_VDP;
    logic VDP_nWAIT;
    logic CLR_FLAGS;
    logic nWAIT;
    logic BUSY;
    logic TIMEOUT;
    logic CONFLICT;

    modport master (
        output nQ, nE, nCS_ROM, nCS_VDP, VDP_nWAIT, CLR_FLAGS,
        input  nWAIT, BUSY, TIMEOUT, CONFLICT
    );

    modport slave (
        input  nQ, nE, nCS_ROM, nCS_VDP, VDP_nWAIT, CLR_FLAGS,
        output nWAIT, BUSY, TIMEOUT, CONFLICT
    );
endinterface

// File: rtl/wait_gen.sv
// nWAIT stretch generator: fixed wait states for ROM, synchronised V9958 wait with forced release.
// One request per bus cycle, started on Q rising and re-armed on E falling.
module wait_gen #(
    parameter int CW        = 8,
    parameter int ROM_WAITS = 8,
    parameter int VDP_LATCH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        MHZ48,
    input  logic        RESET,
    wait_gen_if.slave   bus,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROM_WAIT = 3'd1,
        VDP_ARM  = 3'd2,
        VDP_WAIT = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam bit            ROM_STRETCH = (ROM_WAITS != 0);
    localparam logic [CW-1:0] ROM_LOAD    = ROM_STRETCH ? CW'(ROM_WAITS - 1) : '0;
    localparam logic [CW-1:0] VDP_LOAD    = CW'(VDP_LATCH - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [CW-1:0] tcnt, tcnt_next;
    logic          nwait_r, nwait_next;
    logic          timeout_r, conflict_r;
    logic          timeout_set, conflict_set;
    logic          sync1, sync2;
    logic          nq_q, ne_q;
    logic          qstart, estop, vsync;

    // VDP_nWAIT is asynchronous; nQ/nE are already MHZ48-synchronous and only need one sample.
    always_ff @(posedge MHZ48 or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            nq_q  <= 1'b1;
            ne_q  <= 1'b1;
        end else begin
            sync1 <= bus.VDP_nWAIT;
            sync2 <= sync1;
            nq_q  <= bus.nQ;
            ne_q  <= bus.nE;
        end
    end

    assign vsync  = sync2;
    assign qstart = ~bus.nQ & nq_q;
    assign estop  = bus.nE & ~ne_q;

    always_ff @(posedge MHZ48 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            tcnt       <= '0;
            nwait_r    <= 1'b1;
            timeout_r  <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            tcnt       <= tcnt_next;
            nwait_r    <= nwait_next;
            // A set in the same cycle as the clear pulse wins.
            timeout_r  <= timeout_set  | (timeout_r  & ~bus.CLR_FLAGS);
            conflict_r <= conflict_set | (conflict_r & ~bus.CLR_FLAGS);
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        tcnt_next    = tcnt;
        nwait_next   = nwait_r;
        timeout_set  = 1'b0;
        conflict_set = 1'b0;
        case (state)
            IDLE: begin
                nwait_next = 1'b1;
                if (qstart) begin
                    conflict_set = ~bus.nCS_ROM & ~bus.nCS_VDP;
                    if (!bus.nCS_ROM) begin
                        if (ROM_STRETCH) begin
                            state_next = ROM_WAIT;
                            cnt_next   = ROM_LOAD;
                            nwait_next = 1'b0;
                        end else begin
                            state_next = RELEASE;
                        end
                    end else if (!bus.nCS_VDP) begin
                        state_next = VDP_ARM;
                        cnt_next   = VDP_LOAD;
                        nwait_next = 1'b0;
                    end
                end
            end
            ROM_WAIT: begin
                nwait_next = 1'b0;
                if (cnt == '0) begin
                    state_next = RELEASE;
                    nwait_next = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            VDP_ARM: begin
                nwait_next = 1'b0;
                if (cnt == '0) begin
                    if (!vsync) begin
                        state_next = VDP_WAIT;
                        tcnt_next  = '0;
                    end else begin
                        state_next = RELEASE;
                        nwait_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            VDP_WAIT: begin
                nwait_next = 1'b0;
                if (vsync) begin
                    state_next = RELEASE;
                    nwait_next = 1'b1;
                end else if (tcnt == TO_LAST) begin
                    state_next  = RELEASE;
                    nwait_next  = 1'b1;
                    timeout_set = 1'b1;
                end else begin
                    tcnt_next = tcnt + CW'(1);
                end
            end
            RELEASE: begin
                // Holding here until E falls blocks a second request in the same bus cycle.
                nwait_next = 1'b1;
                if (estop) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                nwait_next = 1'b1;
            end
        endcase
    end

    always_comb begin
        bus.nWAIT    = nwait_r;
        bus.BUSY     = (state != IDLE);
        bus.TIMEOUT  = timeout_r;
        bus.CONFLICT = conflict_r;
        dbg_state    = state;
    end
endmodule

// File: tb/tb_wait_gen.sv
// Bench for wait_gen: bus cycles driven by tasks, nWAIT low-run lengths checked against a queue.
// A second instance built with ROM_WAITS=0 sees the same ROM traffic and must never stretch.
module tb_wait_gen;
    localparam int ROM_W = 8;
    localparam int VDP_L = 4;
    localparam int TO    = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wait_gen_if bus();
    wait_gen_if bus_z();
    logic [2:0] st, st_z;

    wait_gen dut (.MHZ48(clk), .RESET(rst), .bus(bus), .dbg_state(st));
    wait_gen #(.ROM_WAITS(0)) dut_z (.MHZ48(clk), .RESET(rst), .bus(bus_z), .dbg_state(st_z));

    assign bus_z.nQ        = bus.nQ;
    assign bus_z.nE        = bus.nE;
    assign bus_z.nCS_ROM   = bus.nCS_ROM;
    assign bus_z.nCS_VDP   = 1'b1;
    assign bus_z.VDP_nWAIT = bus.VDP_nWAIT;
    assign bus_z.CLR_FLAGS = bus.CLR_FLAGS;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    int low_cnt = 0;
    int z_low = 0;
    bit z_rel = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected nWAIT low length for one bus cycle; vdp_low = cycles the VDP pin is held low.
    function automatic int model_len(input logic rom_n, input logic vdp_n, input int vdp_low);
        int l;
        if (!rom_n) return ROM_W;
        if (!vdp_n) begin
            if (vdp_low <= VDP_L - 2) return VDP_L;
            l = vdp_low + 2;
            return (l > VDP_L + TO) ? VDP_L + TO : l;
        end
        return 0;
    endfunction

    // Monitor: sample #1 after the active edge, measure each nWAIT low run.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            low_cnt = 0;
        end else if (!bus.nWAIT) begin
            low_cnt++;
            check("busy_while_low", bus.BUSY, 1);
        end else if (low_cnt > 0) begin
            if (exp_q.size() == 0) check("unexpected_stretch", low_cnt, 0);
            else check("wait_len", low_cnt, exp_q.pop_front());
            low_cnt = 0;
        end
        if (!bus_z.nWAIT) z_low++;
        if (st_z == 3'd4) z_rel = 1'b1;
    end

    task automatic bus_cycle(input logic rom_n, input logic vdp_n, input int vdp_low,
                             input logic retrig, input logic exp_busy);
        int  exp_len;
        bit  done;
        exp_len = model_len(rom_n, vdp_n, vdp_low);
        @(negedge clk);
        bus.nCS_ROM = rom_n;
        bus.nCS_VDP = vdp_n;
        bus.nQ      = 1'b0;
        if (vdp_low > 0) bus.VDP_nWAIT = 1'b0;
        if (exp_len > 0) exp_q.push_back(16'(exp_len));
        done = 1'b0;
        for (int k = 1; k <= 600 && !done; k++) begin
            @(negedge clk);
            if (k == 2) bus.nE = 1'b0;
            if (k == vdp_low) bus.VDP_nWAIT = 1'b1;
            if (k >= 3 && bus.nWAIT) done = 1'b1;
        end
        if (!done) check("stretch_budget", 0, 1);
        bus.VDP_nWAIT = 1'b1;
        check("busy_after_stretch", bus.BUSY, exp_busy);
        if (retrig) begin
            @(negedge clk) bus.nQ = 1'b1;
            @(negedge clk) bus.nQ = 1'b0;
            repeat (3) @(negedge clk);
            check("retrig_nwait", bus.nWAIT, 1);
            check("retrig_state", st, 4);
        end
        @(negedge clk) bus.nQ = 1'b1;
        @(negedge clk) bus.nE = 1'b1;
        @(negedge clk);
        check("idle_after_estop", st, 0);
        bus.nCS_ROM = 1'b1;
        bus.nCS_VDP = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic clr_flags();
        @(negedge clk) bus.CLR_FLAGS = 1'b1;
        @(negedge clk) bus.CLR_FLAGS = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sel;
        int l;
        bus.nQ = 1'b1; bus.nE = 1'b1; bus.nCS_ROM = 1'b1; bus.nCS_VDP = 1'b1;
        bus.VDP_nWAIT = 1'b1; bus.CLR_FLAGS = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_nwait", bus.nWAIT, 1);
        check("rst_busy", bus.BUSY, 0);
        check("rst_state", st, 0);
        check("rst_timeout", bus.TIMEOUT, 0);
        check("rst_conflict", bus.CONFLICT, 0);

        // ROM access, retrigger attempt while in RELEASE
        bus_cycle(1'b0, 1'b1, 0, 1'b1, 1'b1);
        // VDP pin low 20 cycles -> 22
        bus_cycle(1'b1, 1'b0, 20, 1'b0, 1'b1);
        check("vdp_no_timeout", bus.TIMEOUT, 0);
        // VDP pin stuck low -> forced release
        bus_cycle(1'b1, 1'b0, 1000, 1'b0, 1'b1);
        check("timeout_set", bus.TIMEOUT, 1);
        clr_flags();
        @(negedge clk);
        check("timeout_cleared", bus.TIMEOUT, 0);
        // VDP latch boundaries: pin never low, low 2, low 3
        bus_cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
        bus_cycle(1'b1, 1'b0, 2, 1'b0, 1'b1);
        bus_cycle(1'b1, 1'b0, 3, 1'b0, 1'b1);
        // No select: no request
        bus_cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("idle_conflict", bus.CONFLICT, 0);
        // Both selects low: ROM wins, CONFLICT set
        bus_cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("conflict_set", bus.CONFLICT, 1);

        for (int i = 0; i < 6; i++) begin
            sel = $urandom_range(0, 2);
            l   = $urandom_range(0, 40);
            if (sel == 0)      bus_cycle(1'b0, 1'b1, 0, 1'b0, 1'b1);
            else if (sel == 1) bus_cycle(1'b1, 1'b0, l, 1'b0, 1'b1);
            else               bus_cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
        end

        // Reset three cycles into VDP_WAIT
        @(negedge clk);
        bus.nCS_VDP = 1'b0; bus.nQ = 1'b0; bus.VDP_nWAIT = 1'b0;
        n = 0;
        while (st != 3'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_vdp_wait", st, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_nwait", bus.nWAIT, 1);
        check("rst_mid_state", st, 0);
        check("rst_mid_busy", bus.BUSY, 0);
        check("rst_mid_conflict", bus.CONFLICT, 0);
        check("rst_mid_timeout", bus.TIMEOUT, 0);
        bus.nQ = 1'b1; bus.VDP_nWAIT = 1'b1; bus.nCS_VDP = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        bus_cycle(1'b1, 1'b0, 20, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        check("rom0_never_low", z_low, 0);
        check("rom0_release_seen", z_rel, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
